hqc_rsdecod_errval: RTL



---
 rtl/hqc_rsdecod_errval.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hqc_rsdecod_errval.sv
// hqc_rsdecod_errval: Forney error-value evaluation, writes each RS error value at its symbol position.
// Define HQC_ERRVAL_CONST_TIME_EN to always run DELTA slots so latency does not depend on the error count.
module gfmul (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] p;
    always_comb begin
        p = '0;
        for (int n = 7; n >= 0; n--)
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00) ^ (b_i[n] ? a_i : 8'h00);
    end
    assign p_o = p;
endmodule

module hqc_rsdecod_errval #(
    parameter int PARAM_SECURITY = 128,
    parameter int PARAM_DELTA    = (PARAM_SECURITY == 256) ? 29 : (PARAM_SECURITY == 192) ? 16 : 15,
    parameter int PARAM_N1       = (PARAM_SECURITY == 256) ? 90 : (PARAM_SECURITY == 192) ? 56 : 46,
    parameter int Z_W            = 8*(PARAM_DELTA+1),
    parameter int ERR_W          = 8*PARAM_N1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [Z_W-1:0]      z_i,
    input  logic [PARAM_N1-1:0] loc_i,
    output logic                busy_o,
    output logic [ERR_W-1:0]    err_o,
    output logic                err_valid_o,
    output logic [5:0]          num_err_o
);
    localparam int CW = $clog2(PARAM_N1+1);
    localparam int JW = $clog2(PARAM_DELTA+1);
    localparam logic [CW-1:0] N1M = CW'(PARAM_N1-1);
    localparam logic [CW-1:0] DL  = CW'(PARAM_DELTA);
    localparam logic [CW-1:0] DLM = CW'(PARAM_DELTA-1);
    localparam logic [CW-1:0] INV_END = CW'(12);
    localparam logic [JW-1:0] DJ  = JW'(PARAM_DELTA);
`ifdef HQC_ERRVAL_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SCAN, HORNER, NUM, DEN, INV, WRITE, DONE} state_t;
    state_t state, state_n;

    logic [Z_W-1:0]      zr;
    logic [PARAM_N1-1:0] locr;
    logic [ERR_W-1:0]    err;
    logic [5:0]          num_err;
    logic [CW-1:0]       cnt;
    logic [JW-1:0]       j, count, count_nx, slots, k;
    logic [7:0]          a, ainv, acc, num, d, r, bj, binvj;
    logic [7:0]          beta [PARAM_DELTA];
    logic [7:0]          binv [PARAM_DELTA];
    logic [CW-1:0]       pos  [PARAM_DELTA];
    logic [7:0]          m0a, m0b, m0p, m1a, m1b, m1p;
    logic                hit, last;

    assign k        = cnt[JW-1:0];
    assign hit      = (state == SCAN) && locr[cnt] && (count < DJ);
    assign count_nx = count + JW'(hit);
    assign slots    = CT ? DJ : count;
    assign last     = (j + JW'(1)) >= slots;
    // slots beyond the real error count (constant-time dummies) evaluate at beta = binv = 1
    assign bj       = (j < count) ? beta[j] : 8'h01;
    assign binvj    = (j < count) ? binv[j] : 8'h01;

    always_comb begin
        m1a = (state == SCAN) ? ainv : beta[k];
        m1b = (state == SCAN) ? 8'h8E : binvj;
        m0a = (state == SCAN) ? a :
              (state == HORNER || state == NUM) ? acc :
              (state == DEN) ? d :
              (state == INV) ? ((cnt == '0) ? d : r) : num;
        m0b = (state == SCAN) ? 8'h02 :
              (state == HORNER) ? binvj :
              (state == NUM) ? bj :
              (state == DEN) ? (8'h01 ^ m1p) :
              (state == INV) ? (cnt[0] ? d : m0a) : r;
    end

    gfmul u_mul0 (.a_i(m0a), .b_i(m0b), .p_o(m0p));
    gfmul u_mul1 (.a_i(m1a), .b_i(m1b), .p_o(m1p));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = SCAN;
            SCAN:    if (cnt == N1M) state_n = (count_nx == '0 && !CT) ? DONE : HORNER;
            HORNER:  if (cnt == '0) state_n = NUM;
            NUM:     state_n = DEN;
            DEN:     if (cnt == DLM) state_n = INV;
            INV:     if (cnt == INV_END) state_n = WRITE;
            WRITE:   state_n = last ? DONE : HORNER;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zr <= '0; locr <= '0; err <= '0; num_err <= '0; cnt <= '0; j <= '0; count <= '0;
            a <= '0; ainv <= '0; acc <= '0; num <= '0; d <= '0; r <= '0;
            for (int n = 0; n < PARAM_DELTA; n++) begin
                beta[n] <= '0;
                binv[n] <= '0;
                pos[n]  <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    zr <= z_i; locr <= loc_i; err <= '0; num_err <= '0;
                    a <= 8'h01; ainv <= 8'h01; cnt <= '0; count <= '0;
                end
                SCAN: begin
                    a <= m0p; ainv <= m1p; count <= count_nx;
                    if (hit) begin
                        beta[count] <= a;
                        binv[count] <= ainv;
                        pos[count]  <= cnt;
                    end
                    cnt <= (cnt == N1M) ? DL : cnt + CW'(1);
                    if (cnt == N1M) begin
                        num_err <= 6'(count_nx); j <= '0; acc <= '0;
                    end
                end
                HORNER: begin
                    acc <= m0p ^ zr[8*cnt +: 8];
                    cnt <= (cnt == '0) ? '0 : cnt - CW'(1);
                end
                NUM: begin
                    num <= m0p; d <= 8'h01; cnt <= '0;
                end
                DEN: begin
                    if (k != j && k < count) d <= m0p;
                    cnt <= (cnt == DLM) ? '0 : cnt + CW'(1);
                end
                INV: begin
                    r <= m0p; cnt <= cnt + CW'(1);
                end
                WRITE: begin
                    if (j < count) err[8*pos[j] +: 8] <= m0p;
                    j <= j + JW'(1); cnt <= DL; acc <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state != IDLE) && (state != DONE);
    assign err_valid_o = (state == DONE);
    assign err_o       = err;
    assign num_err_o   = num_err;
endmodule
